// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples s_in with clk, recovers bytes LSB first,
// and hands them out on a valid/ready holding register with error pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            busy_q, busy_d;
    logic            meta_q;
    logic            sync_q;
    logic            deliver;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= s_in;
            sync_q <= meta_q;
        end
    end

    // FSM, bit timing, shift register and holding register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_ARM;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state: sample points, byte assembly and delivery decisions
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        deliver   = 1'b0;

        // A handshake frees the holding register; a delivery below
        // in the same cycle reloads it.
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_ARM: begin
                cnt_d = '0;
                if (sync_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (!sync_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!sync_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = sync_q;
                    bit_idx_d        = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (sync_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Line still low: wait for it to go high again
                        // before hunting for the next start bit.
                        ferr_d  = 1'b1;
                        state_d = S_ARM;
                    end
                end
            end
            default: begin
                state_d = S_ARM;
                cnt_d   = '0;
            end
        endcase

        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Registered busy so it reads 0 while reset holds the FSM in ARM
    always_comb begin
        busy_d = (state_d != S_IDLE);
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;
    assign busy        = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8N1 UART link. It is the far end of the `s_out` line driven by the top-level LFSR → ASCII → FIFO → UART transmit chain. The block oversamples the asynchronous serial input with the system clock, recovers each byte (LSB first), and presents it on a valid/ready handshake. It reports framing errors and overruns, so a loopback top can check the transmit path end to end.

## Interface
- `CLKS_PER_BIT`, default 434 — system clocks per bit period (50 MHz / 115200 baud); must be ≥ 4; `HALF = CLKS_PER_BIT/2`, truncating division.
- `clk`  input  1 — system clock; all state updates on the rising edge.
- `rst`  input  1 — reset, asynchronous and active-low; asserted when 0.
- `s_in`  input  1 — serial line; asynchronous to `clk`; idle high.
- `rx_data`  output  8 — last received byte; valid while `rx_valid` = 1.
- `rx_valid`  output  1 — byte available; held until consumed.
- `rx_ready`  input  1 — consumer accepts `rx_data` on a cycle where `rx_valid & rx_ready`.
- `framing_err`  output  1 — one-cycle pulse when the stop bit is sampled low.
- `overrun`  output  1 — one-cycle pulse when a good byte is dropped because the holding register was full.
- `busy`  output  1 — high whenever the FSM is not in IDLE.

## Operation
- Input path: `s_in` passes through a 2-flop synchronizer, giving `s_sync`. Both flops reset to 1. All decisions use `s_sync` only.
- One bit counter `cnt` (width `$clog2(CLKS_PER_BIT)`) clears on every state entry and on every sample. One 3-bit index `bit_idx` counts data bits.
- FSM states:
  - ARM (reset state): wait until `s_sync` = 1, then go to IDLE. This prevents a false start when reset is released mid-frame or during a break.
  - IDLE: when `s_sync` = 0, go to START.
  - START: when `cnt` = HALF−1, sample `s_sync`. If 0, go to DATA. If 1, the low was a glitch: go to IDLE with no output activity.
  - DATA: when `cnt` = CLKS_PER_BIT−1, shift `s_sync` into the shift register at bit `bit_idx` (LSB first) and increment `bit_idx`. After bit 7, go to STOP.
  - STOP: when `cnt` = CLKS_PER_BIT−1, sample the stop bit.
    - If 1: deliver the byte (see holding register), then go to IDLE.
    - If 0: pulse `framing_err`, discard the byte, then go to ARM.
- The receiver returns to IDLE at mid-stop-bit. A start bit immediately following the stop bit is therefore caught (back-to-back frames).
- Holding register:
  - Delivery with `rx_valid` = 0: load `rx_data`, set `rx_valid`.
  - Delivery with `rx_valid` = 1 and `rx_ready` = 1 in the same cycle: load the new byte, keep `rx_valid` = 1, no overrun.
  - Delivery with `rx_valid` = 1 and `rx_ready` = 0: keep the old byte, drop the new one, pulse `overrun`.
  - `rx_valid & rx_ready` with no delivery that cycle: clear `rx_valid`. `rx_data` keeps its value.
- Reset, anywhere including mid-frame, produces these values immediately:
  - state = ARM, `cnt` = 0, `bit_idx` = 0, shift register = 0
  - `rx_data` = 0x00, `rx_valid` = 0, `framing_err` = 0, `overrun` = 0, `busy` = 0
  - synchronizer flops = 1

## Timing
- Let t0 be the first rising edge at which `s_in` is sampled 0, with the FSM in IDLE.
  - `s_sync` goes low after t0+1.
  - START is entered at t0+2.
  - Start-bit sample at t0+2+HALF.
  - Data bit k is sampled at t0+2+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit is sampled at t0+2+HALF+9·CLKS_PER_BIT.
- `rx_valid`, `framing_err` and `overrun` update on the edge that samples the stop bit. All are registered outputs.
- `busy` is high from entry to START through the stop sample. It is also high in ARM.
- Throughput: one byte per 10·CLKS_PER_BIT cycles, sustained with no gaps between frames.
- Tolerated baud mismatch: ±4% for CLKS_PER_BIT ≥ 16.

## Test plan
Tests use CLKS_PER_BIT = 16 unless noted.
- **Single byte:** send 0x41 as an 8N1 frame, with `rx_ready` held 0 → `rx_valid` rises 154 cycles after t0 with `rx_data` = 0x41. `rx_valid` stays high until `rx_ready` is pulsed, then clears on the next edge.
- **Back-to-back with consumer:** send 0x55, 0xAA, 0x00, 0xFF with no idle gap, `rx_ready` tied 1 → four `rx_valid` cycles spaced 160 cycles apart carrying those values; `overrun` and `framing_err` stay 0.
- **Overrun:** send 0x31 then 0x32, `rx_ready` = 0 → `overrun` pulses once at the second stop sample; `rx_data` stays 0x31.
- **Simultaneous accept:** repeat the overrun case, but pulse `rx_ready` exactly on the second stop-sample edge → `rx_data` = 0x32, `rx_valid` stays 1, no `overrun`.
- **Framing error and glitch rejection:**
  - Send a frame with stop bit 0 → one `framing_err` pulse, `rx_valid` stays 0, FSM waits in ARM until the line returns high; a following 0x7E is then received correctly.
  - A 3-cycle low glitch on an idle line → no output activity; `busy` drops within HALF+2 cycles.
- **Reset mid-frame:** assert `rst` = 0 during data bit 4, release it while the line is low, then send 0x5A → the partial frame produces nothing, and 0x5A is received correctly. Also loop back the full transmit top with CLKS_PER_BIT matched to the transmitter → received bytes equal the FIFO output sequence.
